membus_mem: RTL and testbench
=============================

MEMBUS_MEM -- requirements
Module: membus_mem

Interface
REQ-001 Parameter NPORTS, default 4, number of membus ports (1..4).
REQ-002 Parameter ADDR_W, default 14, words = 2**ADDR_W (1..15).
REQ-003 Parameter SEL_BASE, default 0, 4-bit module select matched against membus_sel.
REQ-004 Parameter FMC, default 0, value of membus_fmc_select this module answers to.
REQ-005 Parameter RD_LAT, default 2, cycles from addr_ack to rd_rs (1..15).
REQ-006 clk  in  1  single system clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 power  in  1  module powered; low = ignore all requests.
REQ-009 membus_rq_cyc  in  NPORTS  per-port cycle request.
REQ-010 membus_rd_rq / membus_wr_rq  in  NPORTS each  per-port read / write request; both set = read-modify-write.
REQ-011 membus_ma  in  15*NPORTS  per-port word address (bits 21:35), port p at slice p.
REQ-012 membus_sel  in  4*NPORTS  per-port module select (bits 18:21).
REQ-013 membus_fmc_select  in  NPORTS  per-port fast-memory select.
REQ-014 membus_mb_in  in  36*NPORTS  per-port write data.
REQ-015 membus_wr_rs  in  NPORTS  per-port write restart (write data valid).
REQ-016 membus_mb_out  out  36*NPORTS  per-port read data, zero on non-owning ports.
REQ-017 membus_addr_ack / membus_rd_rs  out  NPORTS each  per-port one-cycle pulses.

Function
REQ-018 Port p selected when rq_cyc[p] & power & fmc_select[p]==FMC & sel[p] high bits match SEL_BASE for bits not covered by ADDR_W.
REQ-019 FSM states IDLE, ACK, RDLAT, RDRS, WRWAIT, WRDONE; one cycle in progress at a time.
REQ-020 IDLE: among selected ports, lowest index wins; latch port, ma[ADDR_W-1:0], rd/wr flags; go ACK.
REQ-021 ACK: addr_ack[owner]=1 one cycle; then RDLAT if rd_rq, else WRWAIT.
REQ-022 RDLAT: counter counts RD_LAT-1 cycles, then RDRS.
REQ-023 RDRS: rd_rs[owner]=1 one cycle, mb_out[owner]=mem[addr]; mb_out held until owner drops rq_cyc; go WRWAIT if wr flag, else IDLE once rq_cyc[owner] low.
REQ-024 WRWAIT: on wr_rs[owner]=1, mem[addr]<=mb_in[owner]; go WRDONE.
REQ-025 WRDONE: wait for rq_cyc[owner] low, then IDLE; no re-grant to same port same cycle.
REQ-026 Owner dropping rq_cyc before completion aborts to IDLE next cycle with no memory write.
REQ-027 Requests from non-owning ports are held off (no ack) until IDLE; no request is lost while asserted.
REQ-028 power low during a cycle forces IDLE next cycle, no write, outputs zero.
REQ-029 wr_rs outside WRWAIT is ignored.
REQ-030 Address wraps modulo 2**ADDR_W; upper ma bits not in ADDR_W ignored.

Reset
REQ-031 reset forces IDLE, counter 0, all addr_ack, rd_rs, mb_out 0.
REQ-032 Memory contents are not cleared by reset.
REQ-033 Reset mid-cycle abandons the cycle; no partial write.

Configuration
REQ-034 Macro MEMBUS_CYCLE_COUNT_EN defined: extra output cycle_count (out, 32) increments once per completed cycle (RDRS-exit read-only or WRWAIT write), wraps at 2**32, reset 0.
REQ-035 Macro undefined: port cycle_count absent, no counter logic.

Verification
REQ-036 Write 36'o254200000001 to addr 'o1736 port 0 (wr_rq, wr_rs after ack) then read -> addr_ack 1 pulse, rd_rs RD_LAT cycles after ack, mb_out=36'o254200000001.
REQ-037 Ports 0 and 2 request same cycle -> port 0 acked first; port 2 acked only after port 0 drops rq_cyc.
REQ-038 RMW on addr 'o42 holding 36'o334000000000, write 0 -> rd_rs returns 36'o334000000000, subsequent read returns 0.
REQ-039 fmc_select=1 with FMC=0, or sel mismatch -> no addr_ack for 100 cycles.
REQ-040 reset asserted in WRWAIT, then read same addr -> old value returned, outputs 0 during reset.
REQ-041 With MEMBUS_CYCLE_COUNT_EN, 5 reads + 3 writes -> cycle_count=8; aborted cycle does not count.

Source files
------------

// File: rtl/membus_mem.sv
// membus_mem: multi-port membus memory module with fixed-priority arbitration and registered handshakes
//   clk, reset (async, active-high), power
//   membus_rq_cyc/rd_rq/wr_rq/fmc_select/wr_rs [NPORTS]   per-port request and control
//   membus_ma [15*NPORTS], membus_sel [4*NPORTS], membus_mb_in [36*NPORTS]   per-port address, select, write data
//   membus_mb_out [36*NPORTS], membus_addr_ack/rd_rs [NPORTS]   per-port read data and handshake pulses
//   MEMBUS_CYCLE_COUNT_EN: adds cycle_count [32], the number of completed cycles
module membus_mem #(
  parameter int NPORTS = 4,
  parameter int ADDR_W = 14,
  parameter int SEL_BASE = 0,
  parameter int FMC = 0,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 power,
  input  logic [NPORTS-1:0]    membus_rq_cyc,
  input  logic [NPORTS-1:0]    membus_rd_rq,
  input  logic [NPORTS-1:0]    membus_wr_rq,
  input  logic [15*NPORTS-1:0] membus_ma,
  input  logic [4*NPORTS-1:0]  membus_sel,
  input  logic [NPORTS-1:0]    membus_fmc_select,
  input  logic [36*NPORTS-1:0] membus_mb_in,
  input  logic [NPORTS-1:0]    membus_wr_rs,
  output logic [36*NPORTS-1:0] membus_mb_out,
  output logic [NPORTS-1:0]    membus_addr_ack,
  output logic [NPORTS-1:0]    membus_rd_rs
`ifdef MEMBUS_CYCLE_COUNT_EN
  ,output logic [31:0]         cycle_count
`endif
);
  localparam int OW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  // sel[0] aliases ma bit 14, so a 15-bit module only decodes sel[3:1]
  localparam logic [3:0] SEL_MASK = ADDR_W > 14 ? 4'he : 4'hf;
  localparam logic [3:0] LAST = 4'(RD_LAT > 1 ? RD_LAT - 2 : 0);
  typedef enum logic [2:0] {IDLE, ACK, RDLAT, RDRS, WRWAIT, WRDONE} state_t;
  state_t state;
  logic [35:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] ma_a [NPORTS];
  logic [3:0] sel_a [NPORTS];
  logic [35:0] din_a [NPORTS];
  logic [NPORTS-1:0] hit, oh;
  logic [OW-1:0] owner, win;
  logic [ADDR_W-1:0] addr;
  logic [3:0] cnt;
  logic [35:0] rdata;
  logic rd_f, wr_f, rvalid, live, ent_rd, we;
  logic unused_ma;
  assign unused_ma = ^membus_ma;
  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    assign ma_a[i] = membus_ma[15*i +: ADDR_W];
    assign sel_a[i] = membus_sel[4*i +: 4];
    assign din_a[i] = membus_mb_in[36*i +: 36];
    assign hit[i] = power && membus_rq_cyc[i] && membus_fmc_select[i] == 1'(FMC) &&
                    ((sel_a[i] ^ 4'(SEL_BASE)) & SEL_MASK) == 4'h0;
    assign membus_mb_out[36*i +: 36] = (rvalid && owner == OW'(i)) ? rdata : 36'h0;
  end
  always_comb begin
    win = '0;
    for (int p = NPORTS - 1; p >= 0; p--) win = hit[p] ? OW'(p) : win;
  end
  assign oh = NPORTS'(1) << owner;
  // the cycle stays alive only while its owner holds rq_cyc and the module is powered
  assign live = power && membus_rq_cyc[owner];
  assign ent_rd = live && rd_f && (state == ACK ? RD_LAT == 1 : state == RDLAT && cnt == LAST);
  assign we = live && state == WRWAIT && membus_wr_rs[owner];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din_a[owner];
    if (ent_rd) rdata <= mem[addr];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      owner <= '0;
      addr <= '0;
      rd_f <= 1'b0;
      wr_f <= 1'b0;
      rvalid <= 1'b0;
      membus_addr_ack <= '0;
      membus_rd_rs <= '0;
    end else begin
      membus_addr_ack <= '0;
      membus_rd_rs <= ent_rd ? oh : '0;
      if (state != IDLE && !live) begin
        state <= IDLE;
        cnt <= '0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= rvalid | ent_rd;
        case (state)
          IDLE: if (|hit) begin
            owner <= win;
            addr <= ma_a[win];
            rd_f <= membus_rd_rq[win];
            wr_f <= membus_wr_rq[win];
            membus_addr_ack <= NPORTS'(1) << win;
            state <= ACK;
          end
          ACK: state <= !rd_f ? WRWAIT : ent_rd ? RDRS : RDLAT;
          RDLAT: begin
            cnt <= ent_rd ? 4'd0 : cnt + 4'd1;
            if (ent_rd) state <= RDRS;
          end
          RDRS: if (wr_f) state <= WRWAIT;
          WRWAIT: if (we) state <= WRDONE;
          default: ;
        endcase
      end
    end
  end
`ifdef MEMBUS_CYCLE_COUNT_EN
  // a read-only cycle completes when its owner releases rq_cyc after rd_rs
  logic done;
  assign done = we || (state == RDRS && !wr_f && power && !membus_rq_cyc[owner]);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_count <= '0;
    else if (done) cycle_count <= cycle_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_membus_mem.sv
// tb_membus_mem: directed self-checking bench for membus_mem with default parameters
module tb_membus_mem;
  logic clk = 0, reset = 0, power = 1;
  logic [3:0] rq_cyc = '0, rd_rq = '0, wr_rq = '0, fmc = '0, wr_rs = '0;
  logic [59:0] ma = '0;
  logic [15:0] sel = '0;
  logic [143:0] mb_in = '0;
  logic [143:0] mb_out;
  logic [3:0] addr_ack, rd_rs;
`ifdef MEMBUS_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  membus_mem dut (
    .clk(clk), .reset(reset), .power(power),
    .membus_rq_cyc(rq_cyc), .membus_rd_rq(rd_rq), .membus_wr_rq(wr_rq),
    .membus_ma(ma), .membus_sel(sel), .membus_fmc_select(fmc),
    .membus_mb_in(mb_in), .membus_wr_rs(wr_rs), .membus_mb_out(mb_out),
    .membus_addr_ack(addr_ack), .membus_rd_rs(rd_rs)
`ifdef MEMBUS_CYCLE_COUNT_EN
    , .cycle_count(cycle_count)
`endif
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic xact(input int p, input logic [14:0] a, input logic rd, input logic wr,
                      input logic [35:0] wd, output int ackc, output int lat, output logic [35:0] rdv);
    ackc = 0;
    lat = -1;
    rdv = '0;
    ma[15*p +: 15] = a;
    mb_in[36*p +: 36] = wd;
    rd_rq[p] = rd;
    wr_rq[p] = wr;
    rq_cyc[p] = 1;
    for (int i = 0; i < 50 && ackc == 0; i++) begin
      step;
      if (addr_ack[p]) ackc = 1;
    end
    if (ackc != 0) begin
      if (rd) for (int i = 1; i <= 20 && lat < 0; i++) begin
        step;
        if (addr_ack[p]) ackc++;
        if (rd_rs[p]) begin
          lat = i;
          rdv = mb_out[36*p +: 36];
        end
      end
      if (wr) begin
        wr_rs[p] = 1;
        step;
        if (addr_ack[p]) ackc++;
        step;
        wr_rs[p] = 0;
      end
    end
    rq_cyc[p] = 0;
    rd_rq[p] = 0;
    wr_rq[p] = 0;
    step;
    step;
  endtask
  task automatic abort_write(input int p, input logic [14:0] a, input logic [35:0] wd);
    ma[15*p +: 15] = a;
    mb_in[36*p +: 36] = wd;
    wr_rq[p] = 1;
    rq_cyc[p] = 1;
    for (int i = 0; i < 50 && !addr_ack[p]; i++) step;
    step;
    rq_cyc[p] = 0;
    wr_rq[p] = 0;
    step;
    wr_rs[p] = 1;
    step;
    wr_rs[p] = 0;
    step;
  endtask
  task automatic test_reset;
    reset = 1;
    rq_cyc[0] = 1;
    rd_rq[0] = 1;
    step;
    step;
    n_cmp++; if (addr_ack !== 4'h0) begin n_bad++; $display("FAIL reset_ack got %h want 0", addr_ack); end
    n_cmp++; if (rd_rs !== 4'h0) begin n_bad++; $display("FAIL reset_rd_rs got %h want 0", rd_rs); end
    n_cmp++; if (mb_out !== 144'h0) begin n_bad++; $display("FAIL reset_mb_out got %h want 0", mb_out); end
    rq_cyc[0] = 0;
    rd_rq[0] = 0;
    reset = 0;
    step;
  endtask
  task automatic test_write_read;
    int ackc, lat;
    logic [35:0] v;
    xact(0, 15'o1736, 0, 1, 36'o254200000001, ackc, lat, v);
    n_cmp++; if (ackc !== 1) begin n_bad++; $display("FAIL wr_ack_count got %0d want 1", ackc); end
    xact(0, 15'o1736, 1, 0, 36'h0, ackc, lat, v);
    n_cmp++; if (ackc !== 1) begin n_bad++; $display("FAIL rd_ack_count got %0d want 1", ackc); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_latency got %0d want 2", lat); end
    n_cmp++; if (v !== 36'o254200000001) begin n_bad++; $display("FAIL rd_data got %o want 254200000001", v); end
    n_cmp++; if (mb_out !== 144'h0) begin n_bad++; $display("FAIL mb_out_after_drop got %h want 0", mb_out); end
  endtask
  task automatic test_arbitration;
    int late = 0;
    bit got = 0;
    ma[0 +: 15] = 15'o1736;
    ma[30 +: 15] = 15'o1736;
    rd_rq = 4'b0101;
    rq_cyc = 4'b0101;
    step;
    n_cmp++; if (addr_ack !== 4'b0001) begin n_bad++; $display("FAIL arb_first_ack got %b want 0001", addr_ack); end
    for (int i = 0; i < 10; i++) begin
      step;
      if (addr_ack[2]) late++;
    end
    n_cmp++; if (late !== 0) begin n_bad++; $display("FAIL arb_holdoff got %0d acks want 0", late); end
    n_cmp++; if (mb_out[0 +: 36] !== 36'o254200000001) begin n_bad++; $display("FAIL arb_p0_data got %o want 254200000001", mb_out[0 +: 36]); end
    n_cmp++; if (mb_out[72 +: 36] !== 36'h0) begin n_bad++; $display("FAIL arb_p2_idle_data got %o want 0", mb_out[72 +: 36]); end
    rq_cyc[0] = 0;
    rd_rq[0] = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step;
      got = addr_ack[2];
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL arb_second_ack got %b want 1", got); end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step;
      got = rd_rs[2];
    end
    n_cmp++; if (mb_out[72 +: 36] !== 36'o254200000001) begin n_bad++; $display("FAIL arb_p2_data got %o want 254200000001", mb_out[72 +: 36]); end
    n_cmp++; if (mb_out[0 +: 36] !== 36'h0) begin n_bad++; $display("FAIL arb_p0_nonowner got %o want 0", mb_out[0 +: 36]); end
    rq_cyc[2] = 0;
    rd_rq[2] = 0;
    step;
    step;
  endtask
  task automatic test_rmw;
    int ackc, lat;
    logic [35:0] v;
    xact(1, 15'o42, 0, 1, 36'o334000000000, ackc, lat, v);
    xact(1, 15'o42, 1, 1, 36'h0, ackc, lat, v);
    n_cmp++; if (v !== 36'o334000000000) begin n_bad++; $display("FAIL rmw_old got %o want 334000000000", v); end
    n_cmp++; if (ackc !== 1) begin n_bad++; $display("FAIL rmw_ack_count got %0d want 1", ackc); end
    xact(1, 15'o42, 1, 0, 36'h0, ackc, lat, v);
    n_cmp++; if (v !== 36'h0) begin n_bad++; $display("FAIL rmw_new got %o want 0", v); end
  endtask
  task automatic test_wrap;
    int ackc, lat;
    logic [35:0] v;
    xact(3, 15'o41736, 0, 1, 36'o123456701234, ackc, lat, v);
    xact(0, 15'o1736, 1, 0, 36'h0, ackc, lat, v);
    n_cmp++; if (v !== 36'o123456701234) begin n_bad++; $display("FAIL wrap_data got %o want 123456701234", v); end
  endtask
  task automatic test_back_to_back;
    int ackc, lat;
    logic [35:0] v;
    logic [35:0] pat [3] = '{36'o777777777777, 36'o525252525252, 36'o000000000001};
    for (int k = 0; k < 3; k++) xact(k, 15'(15'o7770 + k), 0, 1, pat[k], ackc, lat, v);
    for (int k = 0; k < 3; k++) begin
      xact(2 - k, 15'(15'o7770 + k), 1, 0, 36'h0, ackc, lat, v);
      n_cmp++; if (v !== pat[k]) begin n_bad++; $display("FAIL b2b_data%0d got %o want %o", k, v, pat[k]); end
    end
  endtask
  task automatic test_select;
    int acks = 0;
    fmc[1] = 1;
    rd_rq[1] = 1;
    rq_cyc[1] = 1;
    for (int i = 0; i < 100; i++) begin
      step;
      if (|addr_ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL fmc_reject got %0d acks want 0", acks); end
    rq_cyc[1] = 0;
    rd_rq[1] = 0;
    fmc[1] = 0;
    acks = 0;
    sel[12 +: 4] = 4'b0001;
    rd_rq[3] = 1;
    rq_cyc[3] = 1;
    for (int i = 0; i < 100; i++) begin
      step;
      if (|addr_ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL sel_reject got %0d acks want 0", acks); end
    rq_cyc[3] = 0;
    rd_rq[3] = 0;
    sel = '0;
    step;
  endtask
  task automatic test_power;
    int acks = 0;
    bit got = 0;
    power = 0;
    rd_rq[1] = 1;
    rq_cyc[1] = 1;
    for (int i = 0; i < 10; i++) begin
      step;
      if (|addr_ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL power_off_ack got %0d want 0", acks); end
    rq_cyc[1] = 0;
    rd_rq[1] = 0;
    power = 1;
    step;
    ma[0 +: 15] = 15'o1736;
    rd_rq[0] = 1;
    rq_cyc[0] = 1;
    for (int i = 0; i < 20 && !got; i++) begin
      step;
      got = rd_rs[0];
    end
    n_cmp++; if (mb_out[0 +: 36] !== 36'o123456701234) begin n_bad++; $display("FAIL power_rd_data got %o want 123456701234", mb_out[0 +: 36]); end
    power = 0;
    step;
    n_cmp++; if (mb_out !== 144'h0) begin n_bad++; $display("FAIL power_drop_out got %h want 0", mb_out); end
    rq_cyc[0] = 0;
    rd_rq[0] = 0;
    power = 1;
    step;
    step;
  endtask
  task automatic test_abort;
    int ackc, lat;
    logic [35:0] v;
    xact(0, 15'o200, 0, 1, 36'o111111111111, ackc, lat, v);
    abort_write(0, 15'o200, 36'o666666666666);
    xact(0, 15'o200, 1, 0, 36'h0, ackc, lat, v);
    n_cmp++; if (v !== 36'o111111111111) begin n_bad++; $display("FAIL abort_nowrite got %o want 111111111111", v); end
  endtask
  task automatic test_reset_wrwait;
    int ackc, lat;
    logic [35:0] v;
    xact(2, 15'o100, 0, 1, 36'o444444444444, ackc, lat, v);
    ma[0 +: 15] = 15'o100;
    mb_in[0 +: 36] = 36'o222222222222;
    wr_rq[0] = 1;
    rq_cyc[0] = 1;
    for (int i = 0; i < 50 && !addr_ack[0]; i++) step;
    step;
    reset = 1;
    wr_rs[0] = 1;
    #1;
    n_cmp++; if ({addr_ack, rd_rs} !== 8'h0) begin n_bad++; $display("FAIL rst_mid_pulses got %h want 0", {addr_ack, rd_rs}); end
    step;
    n_cmp++; if (mb_out !== 144'h0) begin n_bad++; $display("FAIL rst_mid_out got %h want 0", mb_out); end
    step;
    rq_cyc[0] = 0;
    wr_rq[0] = 0;
    wr_rs[0] = 0;
    reset = 0;
    step;
    xact(0, 15'o100, 1, 0, 36'h0, ackc, lat, v);
    n_cmp++; if (v !== 36'o444444444444) begin n_bad++; $display("FAIL rst_mid_old got %o want 444444444444", v); end
  endtask
`ifdef MEMBUS_CYCLE_COUNT_EN
  task automatic test_cycle_count;
    int ackc, lat;
    logic [35:0] v;
    reset = 1;
    step;
    reset = 0;
    step;
    n_cmp++; if (cycle_count !== 32'd0) begin n_bad++; $display("FAIL count_reset got %0d want 0", cycle_count); end
    for (int k = 0; k < 3; k++) xact(k, 15'(15'o300 + k), 0, 1, 36'(k), ackc, lat, v);
    abort_write(1, 15'o300, 36'o7);
    for (int k = 0; k < 5; k++) xact(k % 4, 15'(15'o300 + k % 3), 1, 0, 36'h0, ackc, lat, v);
    n_cmp++; if (cycle_count !== 32'd8) begin n_bad++; $display("FAIL count_total got %0d want 8", cycle_count); end
  endtask
`endif
  initial begin
    test_reset;
    test_write_read;
    test_arbitration;
    test_rmw;
    test_wrap;
    test_back_to_back;
    test_select;
    test_power;
    test_abort;
    test_reset_wrwait;
`ifdef MEMBUS_CYCLE_COUNT_EN
    test_cycle_count;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
